// File: rtl/tile_res_pkg.sv
// Shared types and helpers for the tile result collector.
package tile_res_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam int FLUSH_INTERVAL_DEFAULT = 500;
  localparam int DW_DEFAULT             = 32;

  // Index width for n items, never narrower than one bit.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_res_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr_i, wrapping.
module tile_res_rr_pick
  import tile_res_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SW    = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SW-1:0]    ptr_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [SW-1:0]    idx_o,
  output logic             any_o
);

  logic [SW-1:0] k;

  function automatic logic [SW-1:0] rot(input logic [SW-1:0] p, input int off);
    return SW'((int'(p) + off) % N_REQ);
  endfunction

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      k = rot(ptr_i, off);
      if (!any_o && req_i[k] && mask_i[k]) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule

// File: rtl/tile_res_collector.sv
// Round-robin collector of N_REQ tile result streams onto one tagged output stream
// with periodic flush pulse. Define TILE_RES_LOCK_EN to keep packets contiguous.
module tile_res_collector
  import tile_res_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int FLUSH_INTERVAL = FLUSH_INTERVAL_DEFAULT,
  parameter int DW             = DW_DEFAULT,
  parameter int SW             = src_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [DW-1:0]    req_data [N_REQ],
  input  logic [N_REQ-1:0] req_last,
  output logic [N_REQ-1:0] req_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    out_src,
  output logic             out_last,
  input  logic             out_ready,
  output logic             flush,
  output logic             idle
);

  localparam int CW = src_w(FLUSH_INTERVAL + 1);

  logic             out_valid_q;
  logic [DW-1:0]    out_data_q;
  logic [SW-1:0]    out_src_q;
  logic             out_last_q;
  logic             flush_q;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             load_en, xfer_in, xfer_out, unlocked;
  logic             pick_any;
  logic [N_REQ-1:0] pick_grant, elig;
  logic [SW-1:0]    pick_idx, win_next;

`ifdef TILE_RES_LOCK_EN
  lock_state_e   lock_q;
  logic [SW-1:0] lock_src_q;

  always_comb begin
    elig = '1;
    if (lock_q == LOCKED) begin
      elig             = '0;
      elig[lock_src_q] = 1'b1;
    end
  end

  assign unlocked = (lock_q == UNLOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= UNLOCKED;
      lock_src_q <= '0;
    end else if (xfer_in) begin
      case (lock_q)
        UNLOCKED: if (!req_last[pick_idx]) begin
          lock_q     <= LOCKED;
          lock_src_q <= pick_idx;
        end
        LOCKED: if (req_last[pick_idx]) lock_q <= UNLOCKED;
        default: lock_q <= UNLOCKED;
      endcase
    end
  end
`else
  assign elig     = '1;
  assign unlocked = 1'b1;
`endif

  tile_res_rr_pick #(
    .N_REQ (N_REQ),
    .SW    (SW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .mask_i  (elig),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign load_en   = !out_valid_q || out_ready;
  assign xfer_in   = pick_any && load_en && !rst;
  assign xfer_out  = out_valid_q && out_ready;
  assign req_ready = xfer_in ? pick_grant : '0;
  assign win_next  = (pick_idx == SW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Pointer moves past the winner; with packet lock only on the closing word.
  always_comb begin
    ptr_d = ptr_q;
`ifdef TILE_RES_LOCK_EN
    if (xfer_in && req_last[pick_idx]) ptr_d = win_next;
`else
    if (xfer_in) ptr_d = win_next;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer_out) cnt_d = (cnt_q == CW'(FLUSH_INTERVAL)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
      flush_q     <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (xfer_in) begin
        out_valid_q <= 1'b1;
        out_data_q  <= req_data[pick_idx];
        out_src_q   <= pick_idx;
        out_last_q  <= req_last[pick_idx];
      end else if (xfer_out) begin
        out_valid_q <= 1'b0;
      end
      flush_q <= xfer_out && (cnt_q == CW'(FLUSH_INTERVAL));
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign flush     = flush_q;
  assign idle      = !out_valid_q && !(|req_valid) && unlocked;

endmodule

// File: tb/tb_tile_res_collector.sv
// Directed bench for tile_res_collector (N_REQ=4, FLUSH_INTERVAL=3, DW=16).
module tb_tile_res_collector;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [DW-1:0] req_data [N];
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          flush;
  logic          idle;

  int n_checks = 0;
  int n_fail   = 0;

  tile_res_collector #(
    .N_REQ          (N),
    .FLUSH_INTERVAL (3),
    .DW             (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .flush     (flush),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_flush",     32'(flush),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] cur, exp_d;
    logic          exp_v, exp_rdy;
    for (int i = 0; i < N; i++) req_data[i] = '0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs();
    chk("rst_idle", 32'(idle), 32'd1);
    req_valid = 4'b1010;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();

    // All four requesters continuously valid, out_ready=1
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = DW'(16'h00A0 + i);
    out_ready = 1'b1;
    #1;
    chk("rr_first_ov", 32'(out_valid), 32'd0);
    chk("rr_first_grant", 32'(req_ready), 32'd1);
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk("rr_ov",    32'(out_valid), 32'd1);
      chk("rr_src",   32'(out_src),   32'(k % 4));
      chk("rr_data",  32'(out_data),  32'(16'h00A0 + (k % 4)));
      chk("rr_flush", 32'(flush),     32'((k == 4) || (k == 8)));
      chk("rr_grant", 32'(req_ready), 32'(1) << ((k + 1) % 4));
    end
    req_valid = '0;
    #1;
    chk("rr_drain_grant", 32'(req_ready), 32'd0);
    tick();
    chk("rr_drain_ov",    32'(out_valid), 32'd0);
    chk("rr_drain_idle",  32'(idle),      32'd1);
    chk("rr_drain_flush", 32'(flush),     32'd0);

    // Single requester 2 with toggling out_ready
    req_valid   = 4'b0100;
    cur         = 16'h0200;
    req_data[2] = cur;
    exp_v       = 1'b0;
    exp_d       = '0;
    for (int c = 0; c < 8; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      exp_rdy = !(exp_v && !out_ready);
      chk("bp_grant", 32'(req_ready), exp_rdy ? 32'd4 : 32'd0);
      if (exp_rdy) begin
        exp_v = 1'b1;
        exp_d = cur;
      end
      tick();
      chk("bp_ov", 32'(out_valid), 32'(exp_v));
      chk("bp_data", 32'(out_data), 32'(exp_d));
      if (exp_rdy) begin
        cur         = cur + 1'b1;
        req_data[2] = cur;
      end
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_drain_ov", 32'(out_valid), 32'd0);

`ifdef TILE_RES_LOCK_EN
    // Packet lock: single word from 0 moves ptr to 1, then 3-word packet from 1
    req_valid   = 4'b0001;
    req_data[0] = 16'h0300;
    req_last    = 4'b1111;
    #1;
    chk("lk_g0", 32'(req_ready), 32'd1);
    tick();
    chk("lk_src0", 32'(out_src), 32'd0);
    req_valid   = 4'b0011;
    req_data[1] = 16'h0310;
    req_last    = 4'b1101;
    #1;
    chk("lk_g1a", 32'(req_ready), 32'd2);
    tick();
    chk("lk_w1_src",  32'(out_src),  32'd1);
    chk("lk_w1_data", 32'(out_data), 32'h310);
    chk("lk_w1_last", 32'(out_last), 32'd0);
    req_data[1] = 16'h0311;
    #1;
    chk("lk_g1b", 32'(req_ready), 32'd2);
    tick();
    chk("lk_w2_data", 32'(out_data), 32'h311);
    req_data[1] = 16'h0312;
    req_last    = 4'b1111;
    #1;
    chk("lk_g1c", 32'(req_ready), 32'd2);
    tick();
    chk("lk_w3_src",  32'(out_src),  32'd1);
    chk("lk_w3_data", 32'(out_data), 32'h312);
    chk("lk_w3_last", 32'(out_last), 32'd1);
    req_valid = 4'b0101;
    #1;
    chk("lk_ptr2", 32'(req_ready), 32'd4);
    req_valid = 4'b0001;
    #1;
    chk("lk_g0b", 32'(req_ready), 32'd1);
    tick();
    chk("lk_after_src",  32'(out_src),  32'd0);
    chk("lk_after_data", 32'(out_data), 32'h300);
`endif

    // Reset while holding a word (and locked on 2 when packet lock is built in)
    req_valid   = 4'b0100;
    req_data[2] = 16'h0400;
    req_data[1] = 16'h0410;
    req_last    = 4'b1011;
    out_ready   = 1'b1;
    #1;
    chk("mr_g2", 32'(req_ready), 32'd4);
    tick();
    out_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mr_hold_ov",   32'(out_valid), 32'd1);
    chk("mr_hold_src",  32'(out_src),   32'd2);
    chk("mr_hold_data", 32'(out_data),  32'h400);
    chk("mr_backpress", 32'(req_ready), 32'd0);
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs();
    chk("mr_idle", 32'(idle), 32'd1);
    req_valid = 4'b1010;
    #1;
    chk("mr_rst_grant", 32'(req_ready), 32'd0);
    tick();
    chk("mr_ov_after_edge", 32'(out_valid), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_grant_from0", 32'(req_ready), 32'd2);
    tick();
    chk("mr_src",  32'(out_src),  32'd1);
    chk("mr_data", 32'(out_data), 32'h410);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
